// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI trace buffer: the stored trace entry and the
// capture FSM state encoding.
package rvfi_trace_pkg;

    // Width of the PC/instruction/data/address fields held in a trace entry.
    // The buffer's XLEN parameter must not exceed this; narrower values are
    // zero-extended into the entry.
    localparam int unsigned TRACE_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [63:0]           order;
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] insn;
        logic [4:0]            rd_addr;
        logic [TRACE_XLEN-1:0] rd_wdata;
        logic [TRACE_XLEN-1:0] mem_addr;
        logic [3:0]            rmask;
        logic [3:0]            wmask;
        logic                  trap;
        logic                  intr;
    } trace_entry_t;

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Circular entry storage with read/write pointers and an occupancy count.
// When overwrite_i is set, a push into a full buffer replaces the oldest
// entry instead of being discarded. Storage contents are never reset.
module rvfi_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   overwrite_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wrEn;
    logic             doPop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign doPop   = pop_i && !empty_o;

    // Pointer/count next state; clear wins over push and pop, and a push
    // paired with a pop never overwrites even when the buffer is full.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        wrEn    = 1'b0;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else if (push_i && doPop) begin
            wrEn    = 1'b1;
            wrPtr_d = wrPtr_q + PW'(1);
            rdPtr_d = rdPtr_q + PW'(1);
        end else if (push_i) begin
            if (!full_o) begin
                wrEn    = 1'b1;
                wrPtr_d = wrPtr_q + PW'(1);
                count_d = count_q + CW'(1);
            end else if (overwrite_i) begin
                wrEn    = 1'b1;
                wrPtr_d = wrPtr_q + PW'(1);
                rdPtr_d = rdPtr_q + PW'(1);
            end
        end else if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage, deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI trace buffer: captures retired instructions while armed, keeps the
// most recent history until a trap or PC-match trigger, then records a
// fixed number of post-trigger entries and stops. Entries drain
// first-word-fall-through through a valid/ready port at any time.
module rvfi_trace_buffer
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned POST_TRIG = 4,
    parameter int unsigned DROP_W    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   arm_i,
    input  logic                   clear_i,
    input  logic                   trig_pc_en_i,
    input  logic [XLEN-1:0]        trig_pc_i,
    input  logic                   rvfi_valid_i,
    input  logic [63:0]            rvfi_order_i,
    input  logic [XLEN-1:0]        rvfi_insn_i,
    input  logic                   rvfi_trap_i,
    input  logic                   rvfi_intr_i,
    input  logic [XLEN-1:0]        rvfi_pc_rdata_i,
    input  logic [4:0]             rvfi_rd_addr_i,
    input  logic [XLEN-1:0]        rvfi_rd_wdata_i,
    input  logic [XLEN-1:0]        rvfi_mem_addr_i,
    input  logic [3:0]             rvfi_mem_rmask_i,
    input  logic [3:0]             rvfi_mem_wmask_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output trace_entry_t           out_entry_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [1:0]             state_o,
    output logic [DROP_W-1:0]      drop_cnt_o
);

    localparam int unsigned PCW = $clog2(DEPTH);

    trace_state_e      state_q, state_d;
    logic [PCW-1:0]    postCnt_q, postCnt_d;
    logic [DROP_W-1:0] dropCnt_q, dropCnt_d;
    trace_entry_t      newEntry;
    logic              capture;
    logic              trigger;
    logic              pop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              drop;

    assign capture     = rvfi_valid_i && ((state_q == ST_ARMED) || (state_q == ST_POST));
    assign trigger     = capture && (state_q == ST_ARMED) &&
                         (rvfi_trap_i || (trig_pc_en_i && (rvfi_pc_rdata_i == trig_pc_i)));
    assign out_valid_o = !fifoEmpty;
    assign pop         = out_valid_o && out_ready_i;
    assign drop        = capture && fifoFull && !pop && !clear_i;
    assign state_o     = state_q;
    assign drop_cnt_o  = dropCnt_q;

    // Pack the current RVFI retirement into a trace entry.
    always_comb begin
        newEntry          = '0;
        newEntry.order    = rvfi_order_i;
        newEntry.pc       = TRACE_XLEN'(rvfi_pc_rdata_i);
        newEntry.insn     = TRACE_XLEN'(rvfi_insn_i);
        newEntry.rd_addr  = rvfi_rd_addr_i;
        newEntry.rd_wdata = TRACE_XLEN'(rvfi_rd_wdata_i);
        newEntry.mem_addr = TRACE_XLEN'(rvfi_mem_addr_i);
        newEntry.rmask    = rvfi_mem_rmask_i;
        newEntry.wmask    = rvfi_mem_wmask_i;
        newEntry.trap     = rvfi_trap_i;
        newEntry.intr     = rvfi_intr_i;
    end

    // Before the trigger the buffer keeps the newest history, so a full
    // buffer overwrites its oldest entry; after the trigger history is frozen.
    rvfi_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(trace_entry_t))
    ) uFifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .push_i      (capture),
        .pop_i       (pop),
        .overwrite_i (state_q == ST_ARMED),
        .wdata_i     (newEntry),
        .rdata_o     (out_entry_o),
        .count_o     (count_o),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    // Capture FSM next state and post-trigger countdown.
    always_comb begin
        state_d   = state_q;
        postCnt_d = postCnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_i) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trigger) begin
                    postCnt_d = PCW'(POST_TRIG);
                    state_d   = (POST_TRIG > 0) ? ST_POST : ST_DONE;
                end
            end
            ST_POST: begin
                if (capture) begin
                    postCnt_d = postCnt_q - PCW'(1);
                    if (postCnt_q <= PCW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lost-capture counter, saturating at all-ones and zeroed by clear.
    always_comb begin
        dropCnt_d = dropCnt_q;
        if (clear_i) begin
            dropCnt_d = '0;
        end else if (drop && (dropCnt_q != '1)) begin
            dropCnt_d = dropCnt_q + DROP_W'(1);
        end
    end

    // FSM, post counter and drop counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            postCnt_q <= '0;
            dropCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            postCnt_q <= postCnt_d;
            dropCnt_q <= dropCnt_d;
        end
    end

endmodule

// File: doc/rvfi_trace_buffer.md
RVFI_TRACE_BUFFER -- requirements
Module: rvfi_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: trace entries stored; power of two, >= 2.
REQ-002 SHALL have parameter XLEN, default 32: width of PC, instruction, data and address fields.
REQ-003 SHALL have parameter POST_TRIG, default 4: captures accepted after the trigger entry; range 0..DEPTH-1.
REQ-004 SHALL have parameter DROP_W, default 16: drop counter width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports: clk_i in 1, clock; rst_i in 1, asynchronous active-high reset.
REQ-006 SHALL have arm_i in 1, a one-cycle pulse that arms capture, and clear_i in 1, a one-cycle pulse that flushes the buffer.
REQ-007 SHALL have trig_pc_en_i in 1, enabling the PC-match trigger, and trig_pc_i in XLEN, the trigger PC.
REQ-008 SHALL have the RVFI inputs: rvfi_valid_i 1; rvfi_order_i 64; rvfi_insn_i XLEN; rvfi_trap_i 1; rvfi_intr_i 1; rvfi_pc_rdata_i XLEN; rvfi_rd_addr_i 5; rvfi_rd_wdata_i XLEN; rvfi_mem_addr_i XLEN; rvfi_mem_rmask_i 4; rvfi_mem_wmask_i 4.
REQ-009 SHALL have the drain ports out_valid_o out 1, out_ready_i in 1, and out_entry_o out trace_entry_t, the oldest entry.
REQ-010 SHALL have the status outputs count_o out $clog2(DEPTH)+1 (occupancy), state_o out 2 (FSM state) and drop_cnt_o out DROP_W (lost captures).

Function
REQ-011 SHALL implement FSM states IDLE=0, ARMED=1, POST=2 and DONE=3, exposed on state_o.
REQ-012 SHALL define a capture in ARMED or POST as rvfi_valid_i=1; in IDLE and DONE, RVFI input is ignored.
REQ-013 SHALL define the trigger as a capture in ARMED with rvfi_trap_i=1, or with trig_pc_en_i=1 and rvfi_pc_rdata_i==trig_pc_i.
REQ-014 SHALL make these transitions: IDLE->ARMED on arm_i; DONE->ARMED on arm_i; ARMED->POST on trigger with POST_TRIG>0; ARMED->DONE on trigger with POST_TRIG=0; POST->DONE on the capture that decrements the post counter to 0.
REQ-015 SHALL store the trigger entry itself and load the post counter with POST_TRIG on the trigger.
REQ-016 SHALL, in ARMED when full and not popping, overwrite the oldest entry with the capture, advance the read pointer, keep count unchanged and increment drop_cnt_o.
REQ-017 SHALL, in POST when full and not popping, discard the capture, increment drop_cnt_o and still decrement the post counter.
REQ-018 SHALL, on a simultaneous push and pop, perform both with count unchanged, including when full (no overwrite, no drop).
REQ-019 SHALL drive out_valid_o=(count_o!=0) and out_entry_o=storage[rd_ptr] combinationally, first-word fall-through.
REQ-020 SHALL pop when out_valid_o && out_ready_i; a pop is permitted in every state.
REQ-021 SHALL make a capture at edge N visible on out_entry_o in cycle N+1 when the buffer was empty.
REQ-022 SHALL saturate drop_cnt_o at all-ones.
REQ-023 SHALL have clear_i zero the pointers, count_o and drop_cnt_o; clear_i takes priority over same-cycle push and pop; the FSM state is unchanged.
REQ-024 SHALL have arm_i in ARMED or POST do nothing; when arm_i and clear_i coincide, both take effect.
REQ-025 SHALL wrap pointers modulo DEPTH.

Reset
REQ-026 SHALL, on rst_i asserted (async), force: state IDLE; pointers, count_o, post counter and drop_cnt_o 0; out_valid_o 0.
REQ-027 SHALL not reset storage contents; out_entry_o SHALL be don't-care while out_valid_o=0.
REQ-028 SHALL abandon any capture or drain in progress when rst_i is asserted mid-operation; no partial entry SHALL survive.

Structure
REQ-029 SHALL define trace_entry_t (order, pc, insn, rd_addr, rd_wdata, mem_addr, rmask, wmask, trap, intr) and the state enum in a shared package rvfi_trace_pkg.
REQ-030 SHALL use one natural sub-module, rvfi_trace_fifo: a parametrised circular storage with pointers, count and overwrite-oldest option; the FSM, trigger and drop logic SHALL live in the top.

Verification
REQ-031 SHALL test basic capture: arm, 3 captures with pc 0x100/0x104/0x108, out_ready_i=1 -> entries drained in order, count_o returns to 0.
REQ-032 SHALL test wrap: DEPTH=16, arm, 20 captures pc 0x0..0x4C, no trigger, no pop -> count_o=16, drop_cnt_o=4, first drained pc=0x10.
REQ-033 SHALL test trap trigger: POST_TRIG=4, trap on capture #10, 6 more captures -> state_o=DONE after capture #14, 15th capture not stored, count_o=14.
REQ-034 SHALL test PC trigger with POST_TRIG=0: trig_pc_i=0x200, capture pc 0x200 -> state_o=DONE next cycle, last entry pc=0x200.
REQ-035 SHALL test simultaneous full push/pop: full in POST with out_ready_i=1 -> count_o stays 16, drop_cnt_o unchanged.
REQ-036 SHALL test clear and reset: clear_i coincident with push -> count_o=0; rst_i mid-POST -> state_o=IDLE, out_valid_o=0 immediately.
